// File: rtl/vga_str_pkg.sv
// Shared definitions for the VGA_SCA_RGB pixel stream: field positions,
// 640x480@60 timing defaults and the test-pattern selector.
package vga_str_pkg;

    localparam int STR_W   = 26;
    localparam int CNT_W   = 10;

    localparam int R_BIT   = 25;
    localparam int G_BIT   = 24;
    localparam int B_BIT   = 23;
    localparam int XC_HI   = 22;
    localparam int XC_LO   = 13;
    localparam int YC_HI   = 12;
    localparam int YC_LO   = 3;
    localparam int HS_BIT  = 2;
    localparam int VS_BIT  = 1;
    localparam int ACT_BIT = 0;

    localparam int   DEF_H_ACTIVE = 640;
    localparam int   DEF_H_FP     = 16;
    localparam int   DEF_H_SYNC   = 96;
    localparam int   DEF_H_BP     = 48;
    localparam int   DEF_V_ACTIVE = 480;
    localparam int   DEF_V_FP     = 10;
    localparam int   DEF_V_SYNC   = 2;
    localparam int   DEF_V_BP     = 33;
    localparam logic DEF_SYNC_POL = 1'b0;

    typedef enum logic [1:0] {
        PAT_BLACK  = 2'd0,
        PAT_BARS   = 2'd1,
        PAT_CHECK  = 2'd2,
        PAT_BORDER = 2'd3
    } pat_e;

    function automatic logic [STR_W-1:0] pack_stream(
        input logic [2:0]       rgb,
        input logic [CNT_W-1:0] x,
        input logic [CNT_W-1:0] y,
        input logic             hs,
        input logic             vs,
        input logic             act
    );
        logic [STR_W-1:0] s;
        s                = '0;
        s[R_BIT]         = rgb[2];
        s[G_BIT]         = rgb[1];
        s[B_BIT]         = rgb[0];
        s[XC_HI:XC_LO]   = x;
        s[YC_HI:YC_LO]   = y;
        s[HS_BIT]        = hs;
        s[VS_BIT]        = vs;
        s[ACT_BIT]       = act;
        return s;
    endfunction

endpackage

// File: rtl/vga_timing_cnt.sv
// Horizontal/vertical pixel counters with wrap, plus combinational decode of
// sync, active-video and frame-origin for the current counter position.
module vga_timing_cnt
    import vga_str_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = DEF_SYNC_POL
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pix_ce,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic             frame_origin
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] hcnt_reg;
    logic [CNT_W-1:0] vcnt_reg;
    logic             h_wrap;
    logic             v_wrap;

    assign h_wrap = (hcnt_reg == H_LAST);
    assign v_wrap = (vcnt_reg == V_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_reg <= '0;
            vcnt_reg <= '0;
        end else if (pix_ce) begin
            if (h_wrap) begin
                hcnt_reg <= '0;
                vcnt_reg <= v_wrap ? '0 : vcnt_reg + CNT_W'(1);
            end else begin
                hcnt_reg <= hcnt_reg + CNT_W'(1);
            end
        end
    end

    assign hcnt         = hcnt_reg;
    assign vcnt         = vcnt_reg;
    assign active       = (hcnt_reg < H_ACT) && (vcnt_reg < V_ACT);
    // vsync depends on vcnt only, so it switches together with the line wrap
    assign hsync        = ((hcnt_reg >= HS_START) && (hcnt_reg < HS_END)) ? SYNC_POL : ~SYNC_POL;
    assign vsync        = ((vcnt_reg >= VS_START) && (vcnt_reg < VS_END)) ? SYNC_POL : ~SYNC_POL;
    assign frame_origin = (hcnt_reg == '0) && (vcnt_reg == '0);

endmodule

// File: rtl/pxs_str_gen.sv
// Pixel-stream source: VGA timing, frame-latched test pattern and the
// registered 26-bit VGA_SCA_RGB stream with line/frame start pulses.
module pxs_str_gen
    import vga_str_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = DEF_SYNC_POL
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pix_ce,
    input  logic [1:0]       pattern_sel,
    output logic [STR_W-1:0] VGA_SCA_RGB_Str_o,
    output logic             frame_start,
    output logic             line_start
);

    localparam int BAR_W = H_ACTIVE / 8;

    localparam logic [CNT_W-1:0] X_LAST_ACT = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] Y_LAST_ACT = CNT_W'(V_ACTIVE - 1);
    localparam logic [STR_W-1:0] STR_RESET  =
        pack_stream(3'b000, '0, '0, ~SYNC_POL, ~SYNC_POL, 1'b0);

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic             hsync;
    logic             vsync;
    logic             active;
    logic             frame_origin;

    vga_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk          (clk),
        .reset_n      (reset_n),
        .pix_ce       (pix_ce),
        .hcnt         (hcnt),
        .vcnt         (vcnt),
        .hsync        (hsync),
        .vsync        (vsync),
        .active       (active),
        .frame_origin (frame_origin)
    );

    pat_e             pat_reg;
    pat_e             pat_eff;
    logic [7:1]       bar_ge;
    logic [2:0]       bar_idx;
    logic             border;
    logic [2:0]       rgb_next;
    logic [STR_W-1:0] str_reg;
    logic [STR_W-1:0] str_next;
    logic             frame_start_reg;
    logic             line_start_reg;

    // The origin pixel already uses the newly selected pattern; the rest of
    // the frame uses the latched copy so a mid-frame change cannot tear it.
    assign pat_eff = frame_origin ? pat_e'(pattern_sel) : pat_reg;

    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_bar
            assign bar_ge[gi] = (hcnt >= CNT_W'(gi * BAR_W));
        end
    endgenerate

    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (bar_ge[i]) begin
                bar_idx = 3'(i);
            end
        end
    end

    assign border = (hcnt == '0) || (hcnt == X_LAST_ACT) ||
                    (vcnt == '0) || (vcnt == Y_LAST_ACT);

    always_comb begin
        rgb_next = 3'b000;
        if (active) begin
            case (pat_eff)
                PAT_BLACK:  rgb_next = 3'b000;
                PAT_BARS:   rgb_next = bar_idx;
                PAT_CHECK:  rgb_next = {3{hcnt[5] ^ vcnt[5]}};
                PAT_BORDER: rgb_next = {3{border}};
                default:    rgb_next = 3'b000;
            endcase
        end
    end

    assign str_next = pack_stream(rgb_next, hcnt, vcnt, hsync, vsync, active);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            str_reg         <= STR_RESET;
            pat_reg         <= PAT_BLACK;
            frame_start_reg <= 1'b0;
            line_start_reg  <= 1'b0;
        end else if (pix_ce) begin
            str_reg         <= str_next;
            frame_start_reg <= frame_origin;
            line_start_reg  <= (hcnt == '0);
            if (frame_origin) begin
                pat_reg <= pat_eff;
            end
        end else begin
            frame_start_reg <= 1'b0;
            line_start_reg  <= 1'b0;
        end
    end

    assign VGA_SCA_RGB_Str_o = str_reg;
    assign frame_start       = frame_start_reg;
    assign line_start        = line_start_reg;

endmodule

// File: tb/tb_pxs_str_gen.sv
// Directed bench for pxs_str_gen: a full-size 640x480 instance for line
// timing and patterns, and a shrunken-timing instance for frame-level cases.
module tb_pxs_str_gen;

    typedef struct {
        int         x;
        int         y;
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
        logic       act;
        logic       ls;
        logic       fs;
    } vec_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // instance 0: default 640x480 timing
    logic        rst_f, pce_f;
    logic [1:0]  psel_f;
    logic [25:0] str_f;
    logic        fs_f, ls_f;
    // instance 1: 16x6 active, 24x13 total (312 pixels per frame)
    logic        rst_s, pce_s;
    logic [1:0]  psel_s;
    logic [25:0] str_s;
    logic        fs_s, ls_s;

    int checks   = 0;
    int failures = 0;

    pxs_str_gen dut_full (
        .clk               (clk),
        .reset_n           (rst_f),
        .pix_ce            (pce_f),
        .pattern_sel       (psel_f),
        .VGA_SCA_RGB_Str_o (str_f),
        .frame_start       (fs_f),
        .line_start        (ls_f)
    );

    pxs_str_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6),  .V_FP (2), .V_SYNC (2), .V_BP (3),
        .SYNC_POL (1'b0)
    ) dut_small (
        .clk               (clk),
        .reset_n           (rst_s),
        .pix_ce            (pce_s),
        .pattern_sel       (psel_s),
        .VGA_SCA_RGB_Str_o (str_s),
        .frame_start       (fs_s),
        .line_start        (ls_s)
    );

    function automatic logic [25:0] cur_str(input int idx);
        return (idx == 0) ? str_f : str_s;
    endfunction

    function automatic vec_t mk(input int x, input int y, input logic [2:0] rgb,
                                input logic hs, input logic vs, input logic act,
                                input logic ls, input logic fs);
        vec_t v;
        v.x = x; v.y = y; v.rgb = rgb; v.hs = hs; v.vs = vs;
        v.act = act; v.ls = ls; v.fs = fs;
        return v;
    endfunction

    task automatic check_int(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Clock the chosen instance until its stream shows (x,y), then compare.
    task automatic check_vec(input int idx, input string name, input vec_t v);
        logic [25:0] s, exp;
        logic        l, f;
        bit          found;
        found = 1'b0;
        for (int n = 0; n < 30000; n++) begin
            @(posedge clk);
            #1;
            s = cur_str(idx);
            if (int'(s[22:13]) == v.x && int'(s[12:3]) == v.y) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s: position (%0d,%0d) never reached", name, v.x, v.y);
        end else begin
            exp = {v.rgb, 10'(v.x), 10'(v.y), v.hs, v.vs, v.act};
            l   = (idx == 0) ? ls_f : ls_s;
            f   = (idx == 0) ? fs_f : fs_s;
            if (s !== exp || l !== v.ls || f !== v.fs) begin
                failures++;
                $display("FAIL %s: got str=%h ls=%b fs=%b, expected str=%h ls=%b fs=%b",
                         name, s, l, f, exp, v.ls, v.fs);
            end else begin
                $display("ok   %s: (%0d,%0d) str=%h", name, v.x, v.y, s);
            end
        end
    endtask

    // Cycles between two consecutive pulses (line_start or frame_start).
    task automatic measure_period(input int idx, input bit use_fs, input int budget,
                                  output int period);
        int  first;
        logic p;
        first  = -1;
        period = -1;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk);
            #1;
            p = (idx == 0) ? (use_fs ? fs_f : ls_f) : (use_fs ? fs_s : ls_s);
            if (p) begin
                if (first < 0) first = n;
                else begin
                    period = n - first;
                    break;
                end
            end
        end
    endtask

    vec_t full_vec[$];
    vec_t chk_vec[$];
    vec_t small_vec[$];

    initial begin
        int period;
        int last_p;
        bit gate_bad;
        logic [25:0] prev;

        // x, y, rgb, hs, vs, act, ls, fs (bars)
        full_vec.push_back(mk(0,   0, 3'd0, 1, 1, 1, 1, 1));
        full_vec.push_back(mk(79,  0, 3'd0, 1, 1, 1, 0, 0));
        full_vec.push_back(mk(80,  0, 3'd1, 1, 1, 1, 0, 0));
        full_vec.push_back(mk(160, 0, 3'd2, 1, 1, 1, 0, 0));
        full_vec.push_back(mk(639, 0, 3'd7, 1, 1, 1, 0, 0));
        full_vec.push_back(mk(640, 0, 3'd0, 1, 1, 0, 0, 0));
        full_vec.push_back(mk(655, 0, 3'd0, 1, 1, 0, 0, 0));
        full_vec.push_back(mk(656, 0, 3'd0, 0, 1, 0, 0, 0));
        full_vec.push_back(mk(751, 0, 3'd0, 0, 1, 0, 0, 0));
        full_vec.push_back(mk(752, 0, 3'd0, 1, 1, 0, 0, 0));
        full_vec.push_back(mk(799, 0, 3'd0, 1, 1, 0, 0, 0));
        full_vec.push_back(mk(0,   1, 3'd0, 1, 1, 1, 1, 0));
        full_vec.push_back(mk(559, 1, 3'd6, 1, 1, 1, 0, 0));
        full_vec.push_back(mk(560, 1, 3'd7, 1, 1, 1, 0, 0));

        // checkerboard
        chk_vec.push_back(mk(0,  0,  3'd0, 1, 1, 1, 1, 1));
        chk_vec.push_back(mk(31, 0,  3'd0, 1, 1, 1, 0, 0));
        chk_vec.push_back(mk(32, 0,  3'd7, 1, 1, 1, 0, 0));
        chk_vec.push_back(mk(64, 0,  3'd0, 1, 1, 1, 0, 0));
        chk_vec.push_back(mk(0,  31, 3'd0, 1, 1, 1, 1, 0));
        chk_vec.push_back(mk(0,  32, 3'd7, 1, 1, 1, 1, 0));
        chk_vec.push_back(mk(32, 32, 3'd0, 1, 1, 1, 0, 0));

        // small timing: bar width 2, HS low x=18..20, VS low y=8..9
        small_vec.push_back(mk(0,  0,  3'd0, 1, 1, 1, 1, 1));
        small_vec.push_back(mk(2,  0,  3'd1, 1, 1, 1, 0, 0));
        small_vec.push_back(mk(15, 0,  3'd7, 1, 1, 1, 0, 0));
        small_vec.push_back(mk(16, 0,  3'd0, 1, 1, 0, 0, 0));
        small_vec.push_back(mk(18, 0,  3'd0, 0, 1, 0, 0, 0));
        small_vec.push_back(mk(21, 0,  3'd0, 1, 1, 0, 0, 0));
        small_vec.push_back(mk(15, 5,  3'd7, 1, 1, 1, 0, 0));
        small_vec.push_back(mk(0,  6,  3'd0, 1, 1, 0, 1, 0));
        small_vec.push_back(mk(23, 7,  3'd0, 1, 1, 0, 0, 0));
        small_vec.push_back(mk(0,  8,  3'd0, 1, 0, 0, 1, 0));
        small_vec.push_back(mk(23, 9,  3'd0, 1, 0, 0, 0, 0));
        small_vec.push_back(mk(0,  10, 3'd0, 1, 1, 0, 1, 0));
        small_vec.push_back(mk(23, 12, 3'd0, 1, 1, 0, 0, 0));
        small_vec.push_back(mk(0,  0,  3'd0, 1, 1, 1, 1, 1));

        rst_f = 1'b0; pce_f = 1'b1; psel_f = 2'd1;
        rst_s = 1'b0; pce_s = 1'b1; psel_s = 2'd1;
        repeat (3) @(posedge clk);
        #1;
        check_int("reset_stream_full", int'(str_f), 32'h6);
        check_int("reset_pulses_full", int'({ls_f, fs_f}), 0);
        check_int("reset_stream_small", int'(str_s), 32'h6);
        rst_f = 1'b1;
        rst_s = 1'b1;

        foreach (full_vec[i]) check_vec(0, $sformatf("bars_line[%0d]", i), full_vec[i]);

        measure_period(0, 1'b0, 2000, period);
        check_int("line_period", period, 800);

        gate_bad = 1'b0;
        last_p   = -1;
        period   = -1;
        prev     = str_f;
        for (int i = 0; i < 3400; i++) begin
            pce_f = (i % 2 == 0);
            @(posedge clk);
            #1;
            if (!pce_f && (str_f !== prev || ls_f || fs_f)) gate_bad = 1'b1;
            if (ls_f) begin
                if (last_p >= 0) period = i - last_p;
                last_p = i;
            end
            prev = str_f;
        end
        pce_f = 1'b1;
        check_int("gate_hold", int'(gate_bad), 0);
        check_int("gated_line_period", period, 1600);

        // checkerboard on the full-size instance after a fresh reset
        rst_f  = 1'b0;
        psel_f = 2'd2;
        @(posedge clk);
        #1;
        rst_f = 1'b1;
        foreach (chk_vec[i]) check_vec(0, $sformatf("check[%0d]", i), chk_vec[i]);

        // asynchronous mid-frame reset, sampled between clock edges
        @(posedge clk);
        #2;
        rst_s = 1'b0;
        #1;
        check_int("async_reset_small", int'(str_s), 32'h6);
        @(posedge clk);
        #1;
        rst_s = 1'b1;

        foreach (small_vec[i]) check_vec(1, $sformatf("small[%0d]", i), small_vec[i]);

        // pattern change mid-frame must wait for the next frame
        check_vec(1, "sw_pre", mk(0, 3, 3'd0, 1, 1, 1, 1, 0));
        psel_s = 2'd3;
        check_vec(1, "sw_bars_x2",  mk(2,  5, 3'd1, 1, 1, 1, 0, 0));
        check_vec(1, "sw_bars_x15", mk(15, 5, 3'd7, 1, 1, 1, 0, 0));
        check_vec(1, "border_00",   mk(0,  0, 3'd7, 1, 1, 1, 1, 1));
        check_vec(1, "border_11",   mk(1,  1, 3'd0, 1, 1, 1, 0, 0));
        check_vec(1, "border_151",  mk(15, 1, 3'd7, 1, 1, 1, 0, 0));
        psel_s = 2'd0;
        check_vec(1, "border_53",   mk(5,  3, 3'd0, 1, 1, 1, 0, 0));
        check_vec(1, "border_55",   mk(5,  5, 3'd7, 1, 1, 1, 0, 0));
        check_vec(1, "black_00",    mk(0,  0, 3'd0, 1, 1, 1, 1, 1));
        check_vec(1, "black_155",   mk(15, 5, 3'd0, 1, 1, 1, 0, 0));

        measure_period(1, 1'b1, 1000, period);
        check_int("frame_period", period, 312);

        gate_bad = 1'b0;
        last_p   = -1;
        period   = -1;
        prev     = str_s;
        for (int i = 0; i < 1400; i++) begin
            pce_s = (i % 2 == 0);
            @(posedge clk);
            #1;
            if (!pce_s && (str_s !== prev || ls_s || fs_s)) gate_bad = 1'b1;
            if (fs_s) begin
                if (last_p >= 0) period = i - last_p;
                last_p = i;
            end
            prev = str_s;
        end
        pce_s = 1'b1;
        check_int("gate_hold_small", int'(gate_bad), 0);
        check_int("gated_frame_period", period, 624);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
